// File: rtl/riscv_branch_pred_ctrl.sv
// rtl/riscv_branch_pred_ctrl.sv - direct-mapped 2-bit branch predictor with EX-side
// resolution, flush/redirect and a post-flush shadow window that drops wrong-path resolutions.
module riscv_branch_pred_ctrl #(
    parameter int ENTRIES       = 16,
    parameter int SHADOW_CYCLES = 2,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      if_pc,
    output logic             pred_taken,
    output logic [31:0]      pred_target,
    input  logic             ex_valid,
    input  logic             ex_is_branch,
    input  logic             ex_is_jump,
    input  logic [31:0]      ex_pc,
    input  logic             ex_taken,
    input  logic [31:0]      ex_target,
    input  logic             ex_pred_taken,
    input  logic [31:0]      ex_pred_target,
    output logic             flush,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;
    localparam int SH_W  = $clog2(SHADOW_CYCLES + 1);

    typedef enum logic {ST_RUN, ST_SHADOW} state_t;

    logic              r_valid  [ENTRIES];
    logic [TAG_W-1:0]  r_tag    [ENTRIES];
    logic              r_jmp    [ENTRIES];
    logic [1:0]        r_ctr    [ENTRIES];
    logic [31:0]       r_target [ENTRIES];

    state_t            r_state;
    logic [SH_W-1:0]   r_sh_cnt;
    logic [CNT_W-1:0]  r_branch_count;
    logic [CNT_W-1:0]  r_mispredict_count;

    logic [IDX_W-1:0]  w_if_idx;
    logic [TAG_W-1:0]  w_if_tag;
    logic              w_if_hit;
    logic [IDX_W-1:0]  w_ex_idx;
    logic [TAG_W-1:0]  w_ex_tag;
    logic              w_ex_hit;
    logic              w_res;
    logic              w_act;
    logic              w_mis;
    logic              w_unused_lsb;

    assign w_if_idx = if_pc[IDX_W+1:2];
    assign w_if_tag = if_pc[31:IDX_W+2];
    assign w_if_hit = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);

    // Prediction reads the pre-update entry; same-cycle training shows up next cycle.
    assign pred_taken  = !rst && w_if_hit && (r_jmp[w_if_idx] || r_ctr[w_if_idx][1]);
    assign pred_target = r_target[w_if_idx];

    assign w_ex_idx = ex_pc[IDX_W+1:2];
    assign w_ex_tag = ex_pc[31:IDX_W+2];
    assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);

    assign w_res = ex_valid && (ex_is_branch || ex_is_jump) && (r_state == ST_RUN);
    assign w_act = ex_is_jump || ex_taken;
    assign w_mis = w_res && ((w_act != ex_pred_taken) ||
                             (w_act && (ex_pred_target != ex_target)));

    assign flush       = w_mis && !rst;
    assign redirect_pc = flush ? (w_act ? ex_target : ex_pc + 32'd4) : 32'd0;

    assign branch_count     = r_branch_count;
    assign mispredict_count = r_mispredict_count;
    assign w_unused_lsb     = ^if_pc[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_jmp[i]    <= 1'b0;
                r_ctr[i]    <= 2'b01;
                r_target[i] <= 32'd0;
            end
            r_state            <= ST_RUN;
            r_sh_cnt           <= '0;
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else begin
            if (w_res) begin
                if (ex_is_jump) begin
                    r_valid[w_ex_idx]  <= 1'b1;
                    r_tag[w_ex_idx]    <= w_ex_tag;
                    r_jmp[w_ex_idx]    <= 1'b1;
                    r_ctr[w_ex_idx]    <= 2'b11;
                    r_target[w_ex_idx] <= ex_target;
                end else if (w_ex_hit) begin
                    if (ex_taken) begin
                        if (r_ctr[w_ex_idx] != 2'b11)
                            r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] + 2'd1;
                        r_target[w_ex_idx] <= ex_target;
                    end else if (r_ctr[w_ex_idx] != 2'b00) begin
                        r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] - 2'd1;
                    end
                end else begin
                    r_valid[w_ex_idx]  <= 1'b1;
                    r_tag[w_ex_idx]    <= w_ex_tag;
                    r_jmp[w_ex_idx]    <= 1'b0;
                    r_ctr[w_ex_idx]    <= ex_taken ? 2'b10 : 2'b01;
                    r_target[w_ex_idx] <= ex_target;
                end
                if (r_branch_count != '1)
                    r_branch_count <= r_branch_count + 1'b1;
            end
            if (w_mis && (r_mispredict_count != '1))
                r_mispredict_count <= r_mispredict_count + 1'b1;

            // Shadow window: leave in the cycle after the count has reached 1.
            case (r_state)
                ST_RUN: begin
                    if (w_mis) begin
                        r_state  <= ST_SHADOW;
                        r_sh_cnt <= SH_W'(SHADOW_CYCLES);
                    end
                end
                ST_SHADOW: begin
                    if (r_sh_cnt <= SH_W'(1))
                        r_state <= ST_RUN;
                    else
                        r_sh_cnt <= r_sh_cnt - 1'b1;
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_riscv_branch_pred_ctrl.sv
// tb/tb_riscv_branch_pred_ctrl.sv - directed self-checking bench for riscv_branch_pred_ctrl.
module tb_riscv_branch_pred_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid, ex_is_branch, ex_is_jump, ex_taken, ex_pred_taken;
    logic [31:0] ex_pc, ex_target, ex_pred_target;
    logic        flush;
    logic [31:0] redirect_pc;
    logic [15:0] branch_count, mispredict_count;

    int n_total = 0;
    int n_pass  = 0;

    riscv_branch_pred_ctrl #(.ENTRIES(16), .SHADOW_CYCLES(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump),
        .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .flush(flush), .redirect_pc(redirect_pc),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_clear();
        ex_valid = 0; ex_is_branch = 0; ex_is_jump = 0; ex_taken = 0;
        ex_pc = 0; ex_target = 0; ex_pred_taken = 0; ex_pred_target = 0;
    endtask

    task automatic ex_drive(input logic br, input logic jmp, input logic [31:0] pc,
                            input logic tk, input logic [31:0] tgt,
                            input logic ptk, input logic [31:0] ptgt);
        ex_valid = 1; ex_is_branch = br; ex_is_jump = jmp; ex_pc = pc;
        ex_taken = tk; ex_target = tgt; ex_pred_taken = ptk; ex_pred_target = ptgt;
        #1;
    endtask

    task automatic do_reset();
        ex_clear();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic pred_at(input string tag, input logic [31:0] pc,
                           input logic exp_tk, input logic [31:0] exp_tgt);
        if_pc = pc;
        #1;
        chk({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, exp_tk});
        if (exp_tk) chk({tag, "_target"}, pred_target, exp_tgt);
    endtask

    initial begin
        if_pc = 32'h100;
        ex_clear();
        rst = 1;
        tick();
        chk("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
        // Even a mispredicting resolution must not flush while reset is held.
        ex_drive(1, 0, 32'h40, 1, 32'h80, 0, 0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_redirect", redirect_pc, 32'd0);
        ex_clear();
        tick();
        rst = 0;

        // 1: post-reset idle
        #1;
        chk("t1_pred_taken", {31'd0, pred_taken}, 32'd0);
        chk("t1_flush", {31'd0, flush}, 32'd0);
        chk("t1_bc", {16'd0, branch_count}, 32'd0);
        chk("t1_mc", {16'd0, mispredict_count}, 32'd0);

        // 2: first BEQ mispredict allocates the entry
        ex_drive(1, 0, 32'h40, 1, 32'h80, 0, 0);
        chk("t2_flush", {31'd0, flush}, 32'd1);
        chk("t2_redirect", redirect_pc, 32'h80);
        tick();
        ex_clear();
        chk("t2_mc", {16'd0, mispredict_count}, 32'd1);
        chk("t2_bc", {16'd0, branch_count}, 32'd1);
        pred_at("t2_pred", 32'h40, 1, 32'h80);
        tick(); tick();

        // 3: train up to 11, then two not-taken outcomes drop it to 01
        for (int i = 0; i < 4; i++) begin
            ex_drive(1, 0, 32'h40, 1, 32'h80, 1, 32'h80);
            chk("t3_train_flush", {31'd0, flush}, 32'd0);
            tick();
        end
        chk("t3_bc4", {16'd0, branch_count}, 32'd5);
        ex_drive(1, 0, 32'h40, 0, 32'h80, 1, 32'h80);
        chk("t3_nt_flush", {31'd0, flush}, 32'd1);
        chk("t3_nt_redirect", redirect_pc, 32'h44);
        tick();
        ex_clear();
        pred_at("t3_still_taken", 32'h40, 1, 32'h80);
        tick(); tick();
        ex_drive(1, 0, 32'h40, 0, 32'h80, 1, 32'h80);
        chk("t3_nt2_flush", {31'd0, flush}, 32'd1);
        tick();
        ex_clear();
        pred_at("t3_now_not_taken", 32'h40, 0, 32'h0);
        chk("t3_bc", {16'd0, branch_count}, 32'd7);
        chk("t3_mc", {16'd0, mispredict_count}, 32'd3);
        tick(); tick();

        // 4: shadow window ignores two cycles of resolutions
        do_reset();
        ex_drive(1, 0, 32'h40, 1, 32'h80, 0, 0);
        chk("t4_n_flush", {31'd0, flush}, 32'd1);
        tick();
        for (int i = 0; i < 2; i++) begin
            ex_drive(1, 0, 32'h40, 1, 32'h80, 0, 0);
            chk("t4_shadow_flush", {31'd0, flush}, 32'd0);
            chk("t4_shadow_redirect", redirect_pc, 32'd0);
            tick();
        end
        chk("t4_bc_held", {16'd0, branch_count}, 32'd1);
        chk("t4_mc_held", {16'd0, mispredict_count}, 32'd1);
        ex_drive(1, 0, 32'h40, 1, 32'h80, 0, 0);
        chk("t4_n3_flush", {31'd0, flush}, 32'd1);
        tick();
        ex_clear();
        chk("t4_bc", {16'd0, branch_count}, 32'd2);
        chk("t4_mc", {16'd0, mispredict_count}, 32'd2);

        // reset in the middle of the shadow window aborts it
        do_reset();
        ex_drive(1, 0, 32'h40, 0, 32'h80, 0, 0);
        chk("abort_no_mis", {31'd0, flush}, 32'd0);
        ex_drive(1, 0, 32'h40, 1, 32'h80, 0, 0);
        tick();
        ex_clear();
        do_reset();
        ex_drive(1, 0, 32'h40, 1, 32'h80, 0, 0);
        chk("abort_flush", {31'd0, flush}, 32'd1);
        tick();
        ex_clear();
        tick(); tick();

        // 5: aliasing on index 0, with same-cycle predict/update
        do_reset();
        ex_drive(1, 0, 32'h40, 1, 32'h80, 0, 0);
        tick();
        ex_clear();
        tick(); tick();
        pred_at("t5_40_hit", 32'h40, 1, 32'h80);
        pred_at("t5_80_alias", 32'h80, 0, 32'h0);
        ex_drive(1, 0, 32'h80, 1, 32'h300, 0, 0);
        chk("t5_same_cycle_pred", {31'd0, pred_taken}, 32'd0);
        chk("t5_flush", {31'd0, flush}, 32'd1);
        tick();
        ex_clear();
        tick(); tick();
        pred_at("t5_80_hit", 32'h80, 1, 32'h300);
        pred_at("t5_40_evicted", 32'h40, 0, 32'h0);

        // 6: JAL allocate then hit
        do_reset();
        ex_drive(0, 1, 32'h10, 0, 32'h200, 0, 0);
        chk("t6_flush", {31'd0, flush}, 32'd1);
        chk("t6_redirect", redirect_pc, 32'h200);
        tick();
        ex_clear();
        tick(); tick();
        pred_at("t6_pred", 32'h10, 1, 32'h200);
        ex_drive(0, 1, 32'h10, 0, 32'h200, 1, 32'h200);
        chk("t6_rep_flush", {31'd0, flush}, 32'd0);
        chk("t6_rep_redirect", redirect_pc, 32'd0);
        tick();
        ex_clear();
        chk("t6_bc", {16'd0, branch_count}, 32'd2);
        chk("t6_mc", {16'd0, mispredict_count}, 32'd1);

        // branch+jump together behaves as jump; predicted target mismatch; pc+4 wrap
        ex_drive(1, 1, 32'h20, 0, 32'h400, 0, 0);
        chk("both_flush", {31'd0, flush}, 32'd1);
        chk("both_redirect", redirect_pc, 32'h400);
        tick();
        ex_clear();
        tick(); tick();
        pred_at("both_pred", 32'h20, 1, 32'h400);
        ex_drive(1, 0, 32'h60, 1, 32'h500, 1, 32'h504);
        chk("tgt_mis_flush", {31'd0, flush}, 32'd1);
        chk("tgt_mis_redirect", redirect_pc, 32'h500);
        tick();
        ex_clear();
        tick(); tick();
        ex_drive(1, 0, 32'hFFFF_FFFC, 0, 32'h8, 1, 32'h8);
        chk("wrap_redirect", redirect_pc, 32'h0);
        chk("wrap_flush", {31'd0, flush}, 32'd1);
        tick();
        ex_clear();
        chk("final_bc", {16'd0, branch_count}, 32'd5);
        chk("final_mc", {16'd0, mispredict_count}, 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
